bigreg_collector: RTL and testbench

Parametrised collector for PS-written big registers: seed, channel-mux, sample-discriminator and any future multi-word register. It watches the MMIO write stream for a window of WORDS consecutive indices starting at BASE_ID, stages each word with a fresh bit, and commits the assembled value when the PS writes the valid index BASE_ID+WORDS. Committed values queue in a DEPTH-entry FIFO and are presented to the RTL consumer over a valid/ready handshake, with a clear pulse back to the memory map.

---
 rtl/bigreg_collector.sv | 121 ++++++++++++
 tb/tb_bigreg_collector.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bigreg_collector.sv
// Collects a WORDS-word register from MMIO writes and queues committed values in a FIFO.
// Optional feature macro: BIGREG_PARTIAL_EN (commit without requiring every word fresh).
module bigreg_collector #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned WORDS      = 16,
   parameter int unsigned BASE_ID    = 1,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [ID_WIDTH-1:0]         wr_id,
   input  logic [WORD_WIDTH-1:0]       wr_data,
   output logic [WORDS*WORD_WIDTH-1:0] bigreg_data,
   output logic                        bigreg_valid,
   input  logic                        bigreg_ready,
   output logic [WORDS-1:0]            fresh,
   output logic                        clr_pulse,
   output logic                        err_pulse,
   output logic                        ovf_pulse
);

   localparam int unsigned DataW = WORDS * WORD_WIDTH;
   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam logic [ID_WIDTH-1:0] CommitId = ID_WIDTH'(BASE_ID + WORDS);
   localparam logic [PtrW-1:0]     LastPtr  = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0]     FullCnt  = CntW'(DEPTH);

   logic [WORDS-1:0][WORD_WIDTH-1:0] stage_q, stage_d;
   logic [WORDS-1:0]                 fresh_q, fresh_d;
   logic [DataW-1:0]                 mem_q [DEPTH];
   logic [DataW-1:0]                 mem_d [DEPTH];
   logic [PtrW-1:0]                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]                  count_q, count_d;
   logic [DataW-1:0]                 head_q, head_d;
   logic                             valid_q, clr_q, err_q, ovf_q;
   logic                             commit, all_fresh, full, pop, push, err, ovf;

   // Commit decision: the fresh check first, then FIFO room (a same-cycle pop frees a slot).
   always_comb begin
      commit    = wr_en && (wr_id == CommitId);
`ifdef BIGREG_PARTIAL_EN
      all_fresh = 1'b1;
`else
      all_fresh = &fresh_q;
`endif
      full      = (count_q == FullCnt);
      pop       = valid_q && bigreg_ready;
      err       = commit && !all_fresh;
      ovf       = commit && all_fresh && full && !pop;
      push      = commit && all_fresh && !ovf;
   end

   always_comb begin
      stage_d = stage_q;
      fresh_d = fresh_q;
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (wr_en && (wr_id == ID_WIDTH'(BASE_ID + i))) begin
            stage_d[i] = wr_data;
            fresh_d[i] = 1'b1;
         end
      end
      if (commit && all_fresh) begin
         fresh_d = '0;
      end
   end

   // The head is registered from the next-state memory so it tracks pushes into an empty FIFO.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = stage_q;
         wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      head_d  = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q  <= '0;
         fresh_q  <= '0;
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         clr_q    <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         fresh_q  <= fresh_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
         clr_q    <= push;
         err_q    <= err;
         ovf_q    <= ovf;
      end
   end

   assign bigreg_data  = head_q;
   assign bigreg_valid = valid_q;
   assign fresh        = fresh_q;
   assign clr_pulse    = clr_q;
   assign err_pulse    = err_q;
   assign ovf_pulse    = ovf_q;

endmodule

// File: tb/tb_bigreg_collector.sv
// Self-checking bench for bigreg_collector: vector table, directed corner cases and a
// randomized run compared against a queue-based reference model.
module tb_bigreg_collector;

   localparam int W     = 16;
   localparam int N     = 16;
   localparam int BASE  = 1;
   localparam int IDW   = 8;
   localparam int DEPTH = 2;
   localparam int VID   = BASE + N;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr_en;
   logic [IDW-1:0] wr_id;
   logic [W-1:0]   wr_data;
   logic [N*W-1:0] bigreg_data;
   logic           bigreg_valid;
   logic           bigreg_ready;
   logic [N-1:0]   fresh;
   logic           clr_pulse, err_pulse, ovf_pulse;

   int checks = 0;
   int errors = 0;

   bigreg_collector #(
      .WORD_WIDTH(W),
      .WORDS     (N),
      .BASE_ID   (BASE),
      .ID_WIDTH  (IDW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_id       (wr_id),
      .wr_data     (wr_data),
      .bigreg_data (bigreg_data),
      .bigreg_valid(bigreg_valid),
      .bigreg_ready(bigreg_ready),
      .fresh       (fresh),
      .clr_pulse   (clr_pulse),
      .err_pulse   (err_pulse),
      .ovf_pulse   (ovf_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: staging words, fresh mask and an unbounded queue capped at DEPTH by rule.
   logic [W-1:0]   m_stage [N];
   logic [N-1:0]   m_fresh;
   logic [N*W-1:0] m_q [$];
   logic           m_clr, m_err, m_ovf;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] m_flat();
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*W +: W] = m_stage[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_stage[i] = '0;
      m_fresh = '0;
      m_q.delete();
      m_clr = 1'b0;
      m_err = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic model_edge(input logic en, input int id, input logic [W-1:0] d,
                             input logic rdy);
      bit pop;
      bit allf;
      pop   = (m_q.size() > 0) && rdy;
      m_clr = 1'b0;
      m_err = 1'b0;
      m_ovf = 1'b0;
`ifdef BIGREG_PARTIAL_EN
      allf = 1'b1;
`else
      allf = (m_fresh == {N{1'b1}});
`endif
      if (en && id >= BASE && id < BASE + N) begin
         m_stage[id-BASE] = d;
         m_fresh[id-BASE] = 1'b1;
      end else if (en && id == VID) begin
         if (!allf) begin
            m_err = 1'b1;
         end else if (m_q.size() == DEPTH && !pop) begin
            m_ovf   = 1'b1;
            m_fresh = '0;
         end else begin
            m_q.push_back(m_flat());
            m_fresh = '0;
            m_clr   = 1'b1;
         end
      end
      if (pop) void'(m_q.pop_front());
   endtask

   task automatic check_model();
      chk("valid", bigreg_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("data", bigreg_data, m_q[0]);
      chk("fresh", fresh, m_fresh);
      chk("clr_pulse", clr_pulse, m_clr);
      chk("err_pulse", err_pulse, m_err);
      chk("ovf_pulse", ovf_pulse, m_ovf);
   endtask

   // One clock: drive inputs just after an edge, advance the model at the next edge, sample +1.
   task automatic cyc(input logic en, input int id, input logic [W-1:0] d);
      wr_en   = en;
      wr_id   = id[IDW-1:0];
      wr_data = d;
      @(posedge clk);
      model_edge(en, id, d, bigreg_ready);
      #1;
      check_model();
      wr_en = 1'b0;
   endtask

   task automatic write_words(input logic [W-1:0] w0);
      for (int i = 0; i < N; i++) cyc(1'b1, BASE + i, w0 + W'(i));
   endtask

   task automatic write_full(input logic [W-1:0] w0);
      write_words(w0);
      cyc(1'b1, VID, '0);
   endtask

   typedef struct {
      bit           en;
      int           id;
      logic [W-1:0] data;
      bit           rdy;
      bit           e_valid;
      logic [N-1:0] e_fresh;
      bit           e_clr;
      bit           e_err;
      logic [W-1:0] e_w0;
      logic [W-1:0] e_w15;
   } vec_t;

   vec_t tv [$];

   initial begin
      // Full-commit vectors: 16 word writes, commit, 5 held cycles, then a single pop.
      for (int i = 0; i < N; i++)
         tv.push_back('{1'b1, BASE + i, W'(32'h1000 + i), 1'b0, 1'b0,
                        N'((1 << (i + 1)) - 1), 1'b0, 1'b0, W'(0), W'(0)});
      tv.push_back('{1'b1, VID, W'(0), 1'b0, 1'b1, N'(0), 1'b1, 1'b0, W'(16'h1000), W'(16'h100F)});
      for (int i = 0; i < 5; i++)
         tv.push_back('{1'b0, 0, W'(0), 1'b0, 1'b1, N'(0), 1'b0, 1'b0, W'(16'h1000),
                        W'(16'h100F)});
      tv.push_back('{1'b0, 0, W'(0), 1'b1, 1'b0, N'(0), 1'b0, 1'b0, W'(0), W'(0)});

      rst          = 1'b1;
      wr_en        = 1'b0;
      wr_id        = '0;
      wr_data      = '0;
      bigreg_ready = 1'b0;
      model_reset();
      #12;
      chk("reset_valid", bigreg_valid, 1'b0);
      chk("reset_data", bigreg_data, '0);
      chk("reset_fresh", fresh, '0);
      chk("reset_clr", clr_pulse, 1'b0);
      chk("reset_err", err_pulse, 1'b0);
      chk("reset_ovf", ovf_pulse, 1'b0);
      rst = 1'b0;

      foreach (tv[i]) begin
         bigreg_ready = tv[i].rdy;
         cyc(tv[i].en, tv[i].id, tv[i].data);
         chk("tv_valid", bigreg_valid, tv[i].e_valid);
         chk("tv_fresh", fresh, tv[i].e_fresh);
         chk("tv_clr", clr_pulse, tv[i].e_clr);
         chk("tv_err", err_pulse, tv[i].e_err);
         if (tv[i].e_valid) begin
            chk("tv_word0", bigreg_data[W-1:0], tv[i].e_w0);
            chk("tv_word15", bigreg_data[N*W-1 -: W], tv[i].e_w15);
         end
      end
      bigreg_ready = 1'b0;

`ifdef BIGREG_PARTIAL_EN
      cyc(1'b1, 3, 16'hBEEF);
      cyc(1'b1, VID, '0);
      chk("partial_valid", bigreg_valid, 1'b1);
      chk("partial_word2", bigreg_data[2*W +: W], 16'hBEEF);
      chk("partial_word0", bigreg_data[W-1:0], 16'h1000);
      chk("partial_word15", bigreg_data[N*W-1 -: W], 16'h100F);
      chk("partial_err", err_pulse, 1'b0);
      bigreg_ready = 1'b1;
      cyc(1'b0, 0, '0);
      bigreg_ready = 1'b0;
`else
      for (int i = 0; i < N - 1; i++) cyc(1'b1, BASE + i, W'(32'h2000 + i));
      cyc(1'b1, VID, '0);
      chk("incomplete_err", err_pulse, 1'b1);
      chk("incomplete_valid", bigreg_valid, 1'b0);
      chk("incomplete_fresh", fresh, 16'h7FFF);
      cyc(1'b0, 0, '0);
      chk("incomplete_err_once", err_pulse, 1'b0);
      cyc(1'b1, BASE + N - 1, 16'h200F);
      cyc(1'b1, VID, '0);
      chk("completed_clr", clr_pulse, 1'b1);
      chk("completed_word0", bigreg_data[W-1:0], 16'h2000);
      chk("completed_word15", bigreg_data[N*W-1 -: W], 16'h200F);
      bigreg_ready = 1'b1;
      cyc(1'b0, 0, '0);
      bigreg_ready = 1'b0;
`endif

      // Overflow: third commit with a full FIFO and no pop is dropped.
      write_full(16'h000A);
      write_full(16'h000B);
      write_full(16'h000C);
      chk("ovf_pulse", ovf_pulse, 1'b1);
      chk("ovf_clr", clr_pulse, 1'b0);
      chk("ovf_fresh", fresh, '0);
      chk("ovf_head", bigreg_data[W-1:0], 16'h000A);
      bigreg_ready = 1'b1;
      cyc(1'b0, 0, '0);
      chk("ovf_second", bigreg_data[W-1:0], 16'h000B);
      cyc(1'b0, 0, '0);
      chk("ovf_drained", bigreg_valid, 1'b0);
      bigreg_ready = 1'b0;

      // Commit onto a full FIFO while the head is popped.
      write_full(16'h000D);
      write_full(16'h000E);
      write_words(16'h000F);
      bigreg_ready = 1'b1;
      cyc(1'b1, VID, '0);
      chk("fullpop_ovf", ovf_pulse, 1'b0);
      chk("fullpop_clr", clr_pulse, 1'b1);
      chk("fullpop_head", bigreg_data[W-1:0], 16'h000E);
      bigreg_ready = 1'b0;
      cyc(1'b0, 0, '0);
      chk("fullpop_hold", bigreg_data[W-1:0], 16'h000E);
      bigreg_ready = 1'b1;
      cyc(1'b0, 0, '0);
      chk("fullpop_next", bigreg_data[W-1:0], 16'h000F);
      cyc(1'b0, 0, '0);
      chk("fullpop_empty", bigreg_valid, 1'b0);
      bigreg_ready = 1'b0;

      // Ignored indices leave the fresh mask alone.
      cyc(1'b1, 5, 16'h5555);
      cyc(1'b1, 0, 16'hDEAD);
      cyc(1'b1, VID + 1, 16'hBEEF);
      chk("ignored_fresh", fresh, 16'h0010);
      chk("ignored_valid", bigreg_valid, 1'b0);

      // Asynchronous reset in the middle of a cycle with valid data pending.
      write_full(16'h0007);
      cyc(1'b1, 4, 16'h4444);
      #1 rst = 1'b1;
      #1;
      chk("async_valid", bigreg_valid, 1'b0);
      chk("async_fresh", fresh, '0);
      chk("async_data", bigreg_data, '0);
      chk("async_clr", clr_pulse, 1'b0);
      #1 rst = 1'b0;
      model_reset();

      // Randomized traffic against the reference model.
      for (int k = 0; k < 3000; k++) begin
         int id;
         bigreg_ready = ($urandom_range(0, 9) < 3);
         id = ($urandom_range(0, 9) == 0) ? VID : int'($urandom_range(0, VID + 1));
         cyc($urandom_range(0, 4) != 0, id, W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
